sys_ctrl: RTL and testbench
===========================

// Module: sys_ctrl
// PURPOSE
//   Command controller downstream of the UART receiver and upstream of the UART transmit path.
//   Parses byte frames from RX into register-file writes/reads and ALU operations.
//   Queues each response byte toward TX (via TX FIFO write port) and gates the ALU clock.
// PARAMETERS
//   DATA_WIDTH     8   UART byte width; register-file data width
//   ADDR_WIDTH     4   register-file address width
//   FUN_WIDTH      4   ALU function-code width
// PORTS
//   i_CLK            in   1             system clock (REF domain)
//   i_RST            in   1             reset; synchronous, active-high
//   i_RX_P_DATA      in   DATA_WIDTH    received byte (synchronised into i_CLK domain)
//   i_RX_D_VLD       in   1             1-cycle pulse: i_RX_P_DATA valid
//   i_ALU_OUT        in   2*DATA_WIDTH  ALU result
//   i_ALU_OUT_VLD    in   1             1-cycle pulse: i_ALU_OUT valid
//   i_RdData         in   DATA_WIDTH    register-file read data
//   i_RdData_Valid   in   1             1-cycle pulse: i_RdData valid
//   i_FIFO_FULL      in   1             TX FIFO full; no write while high
//   o_ALU_EN         out  1             ALU operation strobe (1 cycle)
//   o_ALU_FUN        out  FUN_WIDTH     ALU function code, held from FUN byte to result
//   o_CLK_GATE_EN    out  1             ALU clock-gate enable
//   o_Address        out  ADDR_WIDTH    register-file address
//   o_WrEn           out  1             register-file write strobe (1 cycle)
//   o_RdEn           out  1             register-file read strobe (1 cycle)
//   o_WrData         out  DATA_WIDTH    register-file write data
//   o_TX_P_DATA      out  DATA_WIDTH    response byte to TX FIFO
//   o_TX_D_VLD       out  1             TX FIFO write strobe (1 cycle, only when !i_FIFO_FULL)
// BEHAVIOUR
//   Reset: all outputs 0, FSM -> IDLE, held result cleared. Reset mid-frame aborts the frame; no strobes.
//   Frames (first byte = opcode; subsequent bytes consumed only on i_RX_D_VLD):
//     0xAA ADDR DATA     -> write RF[ADDR[ADDR_WIDTH-1:0]] = DATA; no response
//     0xBB ADDR          -> read RF[ADDR]; response 1 byte = RdData
//     0xCC A B FUN       -> RF[0]=A, RF[1]=B, ALU(FUN); response 2 bytes, LSB first
//     0xDD FUN           -> ALU(FUN) on current RF[0],RF[1]; response 2 bytes, LSB first
//   Unknown opcode in IDLE: ignored, stay IDLE.
//   States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_B0, TX_B1.
//   WR_DATA byte: o_WrEn=1 with o_Address/o_WrData next cycle (registered), -> IDLE.
//   RD_ADDR byte: o_RdEn=1 next cycle -> RD_WAIT; i_RdData_Valid latches data -> TX_B0 (single byte).
//   OP_A/OP_B byte: o_WrEn to addr 0/1 respectively, registered, 1 cycle.
//   ALU_FUN byte: latch FUN, o_CLK_GATE_EN=1, o_ALU_EN pulses 1 cycle later -> ALU_WAIT.
//   o_CLK_GATE_EN high from FUN byte until ALU_WAIT exits; 0 in every other state.
//   ALU_WAIT: i_ALU_OUT_VLD latches 16-bit result -> TX_B0 (byte[7:0]) -> TX_B1 (byte[15:8]) -> IDLE.
//   TX_Bx: o_TX_D_VLD asserted only in a cycle with i_FIFO_FULL=0; else hold state, byte, no strobe.
//   i_RX_D_VLD while in RD_WAIT/ALU_WAIT/TX_Bx: byte dropped (host must not pipeline frames).
//   i_RdData_Valid/i_ALU_OUT_VLD outside matching WAIT state: ignored.
//   At most one of o_WrEn/o_RdEn/o_ALU_EN/o_TX_D_VLD high in any cycle.
//   Latency: last frame byte -> first o_TX_D_VLD = RF/ALU latency + 1 cycle (FIFO not full).
// STRUCTURE
//   Shared package sys_ctrl_pkg: opcode constants (0xAA/0xBB/0xCC/0xDD), state enum,
//   fixed operand addresses (OP_A_ADDR=0, OP_B_ADDR=1).
//   Single flat module; no sub-module (FSM + result/byte registers only).
// TESTING
//   Reset mid-frame: AA,05 then i_RST=1 then AA,05,3C -> one o_WrEn, addr 5, data 0x3C.
//   RF write then read: AA,03,5A; BB,03 with RdData=0x5A after 1 cyc -> o_TX_D_VLD once, byte 0x5A.
//   ALU with operands: CC,12,34,00 (ADD), ALU_OUT=0x0046 -> WrEn addr0=0x12, addr1=0x34; TX 0x46 then 0x00.
//   FIFO back-pressure: DD,02 with ALU_OUT=0xBEEF, i_FIFO_FULL high 5 cycles -> no strobe while full; then EF, BE in order.
//   Unknown opcode 0x77 then BB,01 -> 0x77 ignored, single o_RdEn addr 1.
//   Clock gate: o_CLK_GATE_EN 0 in IDLE, 1 from FUN byte to ALU result, 0 after.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared constants for the UART command controller: frame opcodes, FSM states
// and the fixed register-file addresses of the two ALU operands.
package sys_ctrl_pkg;

  localparam logic [7:0] OPC_WRITE   = 8'hAA;
  localparam logic [7:0] OPC_READ    = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

  localparam int unsigned OP_A_ADDR = 0;
  localparam int unsigned OP_B_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    ALU_FUN,
    ALU_WAIT,
    TX_B0,
    TX_B1
  } state_t;

endpackage

// File: rtl/sys_ctrl.sv
// Command controller: turns RX byte frames into register-file writes/reads and
// ALU operations, and streams the response bytes into the TX FIFO.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic [DATA_WIDTH-1:0]   i_RX_P_DATA,
  input  logic                    i_RX_D_VLD,
  input  logic [2*DATA_WIDTH-1:0] i_ALU_OUT,
  input  logic                    i_ALU_OUT_VLD,
  input  logic [DATA_WIDTH-1:0]   i_RdData,
  input  logic                    i_RdData_Valid,
  input  logic                    i_FIFO_FULL,
  output logic                    o_ALU_EN,
  output logic [FUN_WIDTH-1:0]    o_ALU_FUN,
  output logic                    o_CLK_GATE_EN,
  output logic [ADDR_WIDTH-1:0]   o_Address,
  output logic                    o_WrEn,
  output logic                    o_RdEn,
  output logic [DATA_WIDTH-1:0]   o_WrData,
  output logic [DATA_WIDTH-1:0]   o_TX_P_DATA,
  output logic                    o_TX_D_VLD
);

  state_t                  state;
  logic [2*DATA_WIDTH-1:0] result;
  logic                    two_byte;
  logic                    alu_arm;

  // NOTE: every register here is written with <= so all updates in this block
  // see the values from before the clock edge, independent of statement order.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state         <= IDLE;
      result        <= '0;
      two_byte      <= 1'b0;
      alu_arm       <= 1'b0;
      o_ALU_EN      <= 1'b0;
      o_ALU_FUN     <= '0;
      o_CLK_GATE_EN <= 1'b0;
      o_Address     <= '0;
      o_WrEn        <= 1'b0;
      o_RdEn        <= 1'b0;
      o_WrData      <= '0;
    end else begin
      o_WrEn   <= 1'b0;
      o_RdEn   <= 1'b0;
      o_ALU_EN <= alu_arm;
      alu_arm  <= 1'b0;

      case (state)
        IDLE: begin
          if (i_RX_D_VLD) begin
            if (i_RX_P_DATA == DATA_WIDTH'(OPC_WRITE))        state <= WR_ADDR;
            else if (i_RX_P_DATA == DATA_WIDTH'(OPC_READ))    state <= RD_ADDR;
            else if (i_RX_P_DATA == DATA_WIDTH'(OPC_ALU_OP))  state <= OP_A;
            else if (i_RX_P_DATA == DATA_WIDTH'(OPC_ALU_NOP)) state <= ALU_FUN;
          end
        end

        WR_ADDR: begin
          if (i_RX_D_VLD) begin
            o_Address <= i_RX_P_DATA[ADDR_WIDTH-1:0];
            state     <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (i_RX_D_VLD) begin
            o_WrData <= i_RX_P_DATA;
            o_WrEn   <= 1'b1;
            state    <= IDLE;
          end
        end

        RD_ADDR: begin
          if (i_RX_D_VLD) begin
            o_Address <= i_RX_P_DATA[ADDR_WIDTH-1:0];
            o_RdEn    <= 1'b1;
            state     <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (i_RdData_Valid) begin
            result   <= {{DATA_WIDTH{1'b0}}, i_RdData};
            two_byte <= 1'b0;
            state    <= TX_B0;
          end
        end

        OP_A: begin
          if (i_RX_D_VLD) begin
            o_Address <= ADDR_WIDTH'(OP_A_ADDR);
            o_WrData  <= i_RX_P_DATA;
            o_WrEn    <= 1'b1;
            state     <= OP_B;
          end
        end

        OP_B: begin
          if (i_RX_D_VLD) begin
            o_Address <= ADDR_WIDTH'(OP_B_ADDR);
            o_WrData  <= i_RX_P_DATA;
            o_WrEn    <= 1'b1;
            state     <= ALU_FUN;
          end
        end

        ALU_FUN: begin
          if (i_RX_D_VLD) begin
            o_ALU_FUN     <= i_RX_P_DATA[FUN_WIDTH-1:0];
            o_CLK_GATE_EN <= 1'b1;
            alu_arm       <= 1'b1;
            state         <= ALU_WAIT;
          end
        end

        ALU_WAIT: begin
          // A result cannot precede the enable strobe, so ignore it until then.
          if (i_ALU_OUT_VLD && !alu_arm) begin
            result        <= i_ALU_OUT;
            two_byte      <= 1'b1;
            o_CLK_GATE_EN <= 1'b0;
            state         <= TX_B0;
          end
        end

        TX_B0: begin
          if (!i_FIFO_FULL) state <= two_byte ? TX_B1 : IDLE;
        end

        TX_B1: begin
          if (!i_FIFO_FULL) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // The write strobe is qualified by the live FIFO-full flag so a byte is
  // never pushed in a cycle where the FIFO reports full.
  always_comb begin
    o_TX_D_VLD  = 1'b0;
    o_TX_P_DATA = '0;
    if (state == TX_B0) begin
      o_TX_D_VLD  = !i_FIFO_FULL;
      o_TX_P_DATA = result[DATA_WIDTH-1:0];
    end else if (state == TX_B1) begin
      o_TX_D_VLD  = !i_FIFO_FULL;
      o_TX_P_DATA = result[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Self-checking bench for sys_ctrl: table-driven frames plus directed sequences
// for mid-frame reset, TX back-pressure and ALU clock-gate timing.
module tb_sys_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   rx_data;
  logic            rx_vld;
  logic [2*DW-1:0] alu_out;
  logic            alu_vld;
  logic [DW-1:0]   rd_data;
  logic            rd_vld;
  logic            fifo_full;

  logic            o_ALU_EN;
  logic [FW-1:0]   o_ALU_FUN;
  logic            o_CLK_GATE_EN;
  logic [AW-1:0]   o_Address;
  logic            o_WrEn;
  logic            o_RdEn;
  logic [DW-1:0]   o_WrData;
  logic [DW-1:0]   o_TX_P_DATA;
  logic            o_TX_D_VLD;

  sys_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) dut (
    .i_CLK          (clk),
    .i_RST          (rst),
    .i_RX_P_DATA    (rx_data),
    .i_RX_D_VLD     (rx_vld),
    .i_ALU_OUT      (alu_out),
    .i_ALU_OUT_VLD  (alu_vld),
    .i_RdData       (rd_data),
    .i_RdData_Valid (rd_vld),
    .i_FIFO_FULL    (fifo_full),
    .o_ALU_EN       (o_ALU_EN),
    .o_ALU_FUN      (o_ALU_FUN),
    .o_CLK_GATE_EN  (o_CLK_GATE_EN),
    .o_Address      (o_Address),
    .o_WrEn         (o_WrEn),
    .o_RdEn         (o_RdEn),
    .o_WrData       (o_WrData),
    .o_TX_P_DATA    (o_TX_P_DATA),
    .o_TX_D_VLD     (o_TX_D_VLD)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Observed strobe traffic, gathered on the falling edge.
  logic [AW+DW-1:0] wr_q[$];
  logic [AW-1:0]    rd_q[$];
  logic [FW-1:0]    fun_q[$];
  logic [DW-1:0]    tx_q[$];
  int multi_viol = 0;
  int full_viol  = 0;
  int gate_viol  = 0;

  // Responses returned by the modelled register file and ALU.
  logic [DW-1:0]   rf_resp;
  logic [2*DW-1:0] alu_resp;

  typedef struct {
    logic [31:0]      frame;    // bytes sent MSB first
    int               nb;
    logic [DW-1:0]    rd_resp;
    logic [2*DW-1:0]  alu_resp;
    int               n_wr;
    int               n_rd;
    int               n_alu;
    int               n_tx;
    logic [AW+DW-1:0] wr_first;
    logic [AW+DW-1:0] wr_last;
    logic [AW-1:0]    rd_addr;
    logic [FW-1:0]    fun;
    logic [2*DW-1:0]  tx;       // {second byte, first byte}
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_vld  = 1'b1;
    @(posedge clk); #1;
    rx_vld  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void clear_logs();
    wr_q.delete();
    rd_q.delete();
    fun_q.delete();
    tx_q.delete();
  endfunction

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if ((int'(o_WrEn) + int'(o_RdEn) + int'(o_ALU_EN) + int'(o_TX_D_VLD)) > 1) multi_viol++;
      if (o_WrEn) wr_q.push_back({o_Address, o_WrData});
      if (o_RdEn) rd_q.push_back(o_Address);
      if (o_ALU_EN) begin
        fun_q.push_back(o_ALU_FUN);
        if (!o_CLK_GATE_EN) gate_viol++;
      end
      if (o_TX_D_VLD) begin
        tx_q.push_back(o_TX_P_DATA);
        if (fifo_full) full_viol++;
        if (o_CLK_GATE_EN) gate_viol++;
      end
    end
  end

  // Register-file and ALU responders: valid one cycle after the strobe.
  initial begin
    rd_vld  = 1'b0;
    alu_vld = 1'b0;
    rd_data = '0;
    alu_out = '0;
    forever begin
      @(negedge clk);
      if (o_RdEn) begin
        @(posedge clk); #1;
        rd_data = rf_resp;
        rd_vld  = 1'b1;
        @(posedge clk); #1;
        rd_vld  = 1'b0;
      end else if (o_ALU_EN) begin
        @(posedge clk); #1;
        alu_out = alu_resp;
        alu_vld = 1'b1;
        @(posedge clk); #1;
        alu_vld = 1'b0;
      end
    end
  end

  initial begin
    rst       = 1'b1;
    rx_data   = '0;
    rx_vld    = 1'b0;
    fifo_full = 1'b0;
    rf_resp   = '0;
    alu_resp  = '0;

    vecs[0] = '{32'hAA035A00, 3, 8'h00, 16'h0000, 1, 0, 0, 0, 12'h35A, 12'h35A, 4'h0, 4'h0, 16'h0000};
    vecs[1] = '{32'hBB030000, 2, 8'h5A, 16'h0000, 0, 1, 0, 1, 12'h000, 12'h000, 4'h3, 4'h0, 16'h005A};
    vecs[2] = '{32'hCC123400, 4, 8'h00, 16'h0046, 2, 0, 1, 2, 12'h012, 12'h134, 4'h0, 4'h0, 16'h0046};
    vecs[3] = '{32'hDD020000, 2, 8'h00, 16'hBEEF, 0, 0, 1, 2, 12'h000, 12'h000, 4'h0, 4'h2, 16'hBEEF};
    vecs[4] = '{32'h77BB0100, 3, 8'h99, 16'h0000, 0, 1, 0, 1, 12'h000, 12'h000, 4'h1, 4'h0, 16'h0099};
    vecs[5] = '{32'hAA1F8000, 3, 8'h00, 16'h0000, 1, 0, 0, 0, 12'hF80, 12'hF80, 4'h0, 4'h0, 16'h0000};

    // Reset state
    idle_cycles(3);
    @(negedge clk);
    check("reset_outputs",
          32'({o_ALU_EN, o_ALU_FUN, o_CLK_GATE_EN, o_Address, o_WrEn, o_RdEn,
               o_WrData, o_TX_P_DATA, o_TX_D_VLD}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      clear_logs();
      rf_resp  = vecs[v].rd_resp;
      alu_resp = vecs[v].alu_resp;
      for (int b = 0; b < vecs[v].nb; b++) send_byte(vecs[v].frame[31-8*b -: 8]);
      idle_cycles(12);
      check($sformatf("v%0d_n_wr", v),  32'(wr_q.size()),  32'(vecs[v].n_wr));
      check($sformatf("v%0d_n_rd", v),  32'(rd_q.size()),  32'(vecs[v].n_rd));
      check($sformatf("v%0d_n_alu", v), 32'(fun_q.size()), 32'(vecs[v].n_alu));
      check($sformatf("v%0d_n_tx", v),  32'(tx_q.size()),  32'(vecs[v].n_tx));
      if (vecs[v].n_wr > 0 && wr_q.size() == vecs[v].n_wr) begin
        check($sformatf("v%0d_wr_first", v), 32'(wr_q[0]), 32'(vecs[v].wr_first));
        check($sformatf("v%0d_wr_last", v),  32'(wr_q[wr_q.size()-1]), 32'(vecs[v].wr_last));
      end
      if (vecs[v].n_rd > 0 && rd_q.size() == vecs[v].n_rd)
        check($sformatf("v%0d_rd_addr", v), 32'(rd_q[0]), 32'(vecs[v].rd_addr));
      if (vecs[v].n_alu > 0 && fun_q.size() == vecs[v].n_alu)
        check($sformatf("v%0d_alu_fun", v), 32'(fun_q[0]), 32'(vecs[v].fun));
      if (vecs[v].n_tx > 0 && tx_q.size() == vecs[v].n_tx) begin
        check($sformatf("v%0d_tx0", v), 32'(tx_q[0]), 32'(vecs[v].tx[7:0]));
        if (vecs[v].n_tx > 1)
          check($sformatf("v%0d_tx1", v), 32'(tx_q[1]), 32'(vecs[v].tx[15:8]));
      end
      @(negedge clk);
      check($sformatf("v%0d_gate_idle", v), 32'(o_CLK_GATE_EN), 32'h0);
    end

    // Reset in the middle of a write frame aborts it
    clear_logs();
    send_byte(8'hAA);
    send_byte(8'h05);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h3C);
    idle_cycles(6);
    check("midrst_n_wr", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() == 1) check("midrst_wr", 32'(wr_q[0]), 32'h53C);

    // TX back-pressure: nothing leaves while full, then LSB/MSB in order
    clear_logs();
    alu_resp  = 16'hBEEF;
    fifo_full = 1'b1;
    send_byte(8'hDD);
    @(negedge clk);
    check("gate_before_fun", 32'(o_CLK_GATE_EN), 32'h0);
    send_byte(8'h02);
    @(negedge clk);
    check("gate_after_fun", 32'(o_CLK_GATE_EN), 32'h1);
    send_byte(8'hAA);   // arrives while waiting on the ALU/FIFO and must be dropped
    idle_cycles(3);
    check("bp_no_tx_while_full", 32'(tx_q.size()), 32'd0);
    fifo_full = 1'b0;
    idle_cycles(6);
    check("bp_n_tx", 32'(tx_q.size()), 32'd2);
    if (tx_q.size() == 2) begin
      check("bp_tx0", 32'(tx_q[0]), 32'hEF);
      check("bp_tx1", 32'(tx_q[1]), 32'hBE);
    end
    @(negedge clk);
    check("gate_after_result", 32'(o_CLK_GATE_EN), 32'h0);

    // The dropped byte must not have started a frame
    clear_logs();
    rf_resp = 8'h77;
    send_byte(8'hBB);
    send_byte(8'h02);
    idle_cycles(8);
    check("drop_n_wr", 32'(wr_q.size()), 32'd0);
    check("drop_n_rd", 32'(rd_q.size()), 32'd1);
    if (tx_q.size() == 1) check("drop_tx", 32'(tx_q[0]), 32'h77);
    else check("drop_n_tx", 32'(tx_q.size()), 32'd1);

    check("one_hot_strobes",     32'(multi_viol), 32'd0);
    check("no_tx_when_full",     32'(full_viol),  32'd0);
    check("gate_during_alu_tx",  32'(gate_viol),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
